ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipeline CPU, directly downstream of the ID/Ex pipeline register. It consumes the decoded operands and control fields, performs the ALU or shifter operation, and resolves branches and jumps. Redirect information (PCSource, PC_branch, PC_jump) and flush requests go back to IF/ID. Results are captured in an internal Ex/Mem pipeline register that supports stall and bubble insertion.

## Interface
**Parameters**
- WIDTH, 32, datapath width; only 32 is supported.

**Ports**
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears the Ex/Mem register.
- valid_Ex  in  1  the ID/Ex slot holds a real instruction.
- PCP4_Ex  in  32  PC+4 of the instruction in Ex.
- Rs_out_Ex, Rt_out_Ex  in  32 each  register file read data.
- offset_Ex  in  32  extended 16-bit immediate.
- Target_Ex  in  26  jump target field.
- Rs_Ex, Rt_Ex, Rd_Ex, Shamt_Ex  in  5 each  register numbers and shift amount.
- ALU_op_Ex  in  4  ALU function.
- Shift_op_Ex  in  2  shifter function.
- ALUSrcB_Ex  in  3  operand-B select.
- ALUShift_Sel_Ex  in  1  1 = shifter result, 0 = ALU result.
- Shift_amountSrc_Ex  in  1  1 = Rs_out[4:0], 0 = Shamt_Ex.
- RegDst_Ex  in  1  1 = Rd_Ex, 0 = Rt_Ex.
- Jump_Ex  in  1  unconditional jump.
- Condition_Ex  in  3  branch condition.
- RegWrite_Ex, MemRead_Ex, MemWrite_Ex  in  1 each  downstream controls.
- stall_in  in  1  Mem stage cannot accept.
- WB_RegWrite, WB_WriteReg, WB_data  in  1/5/32  write-back forwarding source.
- PCSource  out  2  0 = PC+4, 1 = branch, 2 = jump.
- PC_branch, PC_jump  out  32 each  redirect targets.
- flush  out  1  squash IF/ID and ID/Ex this cycle.
- ALU_result_Mem, Rt_out_Mem  out  32 each  registered.
- WriteReg_Mem  out  5  registered.
- RegWrite_Mem, MemRead_Mem, MemWrite_Mem, valid_Mem  out  1 each  registered.

## Operation
- Operand A = Rs value. Operand B by ALUSrcB_Ex:
  - 0: Rt value
  - 1: offset_Ex
  - 2: zero
  - 3: PCP4_Ex (link)
  - 4: {offset_Ex[15:0], 16'h0}
  - other: zero
- ALU_op:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU
  - 8 PASS_B
  - other: 0
  - No overflow trap; 32-bit wrap-around.
- Shift_op operates on the Rt value, amount 0..31:
  - 0 SLL, 1 SRL, 2 SRA, 3 rotate-right.
- Condition, evaluated on the (forwarded) Rs/Rt values:
  - 0 never
  - 1 Rs==Rt, 2 Rs!=Rt
  - 3 Rs<=0, 4 Rs>0, 5 Rs<0, 6 Rs>=0 (signed)
  - 7 never
- Branch and jump targets:
  - PC_branch = PCP4_Ex + (offset_Ex<<2), mod 2^32.
  - PC_jump = {PCP4_Ex[31:28], Target_Ex, 2'b00}.
- A redirect is qualified only when valid_Ex && !stall_in:
  - Jump_Ex → PCSource=2.
  - Else condition true → PCSource=1.
  - Else PCSource=0.
  - flush = (PCSource != 0).
  - Jump has priority over branch.
- Ex/Mem register:
  - stall_in=1: hold all contents.
  - Else, valid_Ex=0: load a bubble (valid_Mem, RegWrite_Mem, MemRead_Mem, MemWrite_Mem = 0; data fields don't-care, implemented as hold).
  - Else: load the result, Rt value, WriteReg, and controls, with valid_Mem=1.
- WriteReg = RegDst_Ex ? Rd_Ex : Rt_Ex. A write to register 0 forces RegWrite_Mem=0.

## Timing
- Redirect and flush are combinational from the Ex inputs, in the same cycle. IF samples NextPC at the next edge.
- Execute latency is 1 cycle: an instruction present at edge N has its results on the Mem outputs after edge N+1.
- Reset (asynchronous assert) clears every registered output to 0. PCSource=0 and flush=0 while reset is high.
- Reset deasserting mid-stall: the register stays 0 until the first non-stalled edge.
- stall_in and a taken branch in the same cycle: no redirect. The branch re-evaluates when the stall releases; upstream holds ID/Ex.

## Configuration
- FORWARD_EN defined:
  - Rs and Rt values are forwarded from Ex/Mem when RegWrite_Mem && WriteReg_Mem==src && src!=0.
  - Otherwise they come from WB when WB_RegWrite && WB_WriteReg==src && src!=0.
  - Mem has priority over WB.
  - Forwarded values feed the ALU, shifter, condition, and Rt_out_Mem.
- FORWARD_EN undefined:
  - Raw Rs_out_Ex/Rt_out_Ex are used.
  - WB_* ports are ignored.
  - The hazard unit must insert stalls instead.

## Test plan
- ADD with Rs=0x7FFFFFFF, Rt=1, RegDst=1, Rd=5 → ALU_result_Mem=0x80000000, WriteReg_Mem=5, valid_Mem=1 one edge later.
- SRA with Rt=0x80000010, Shamt=4, ALUShift_Sel=1 → 0xF8000001.
- BEQ with Rs=Rt=3, PCP4=0x100, offset=0xFFFFFFFE → PCSource=1, PC_branch=0xF8, flush=1. With stall_in=1 → PCSource=0, flush=0, Ex/Mem register held.
- Jump_Ex=1 with Condition=1 true, PCP4=0x40000004, Target=0x10 → PCSource=2, PC_jump=0x40000040.
- FORWARD_EN: back-to-back ADD r3 then SUB r4=r3-r1 → the second result uses the forwarded value. WB and Mem both matching r3 → the Mem value wins. Writing r0 → RegWrite_Mem=0.
- Reset asserted mid-stream between edges → all Mem outputs 0 immediately. valid_Ex=0 → bubble with valid_Mem=0.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: ALU/shifter execute, branch/jump resolution and Ex/Mem register.
// Optional macro FORWARD_EN adds Mem/WB operand forwarding.
module ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_Ex,
  input  logic [WIDTH-1:0] PCP4_Ex,
  input  logic [WIDTH-1:0] Rs_out_Ex,
  input  logic [WIDTH-1:0] Rt_out_Ex,
  input  logic [WIDTH-1:0] offset_Ex,
  input  logic [25:0]      Target_Ex,
  input  logic [4:0]       Rs_Ex,
  input  logic [4:0]       Rt_Ex,
  input  logic [4:0]       Rd_Ex,
  input  logic [4:0]       Shamt_Ex,
  input  logic [3:0]       ALU_op_Ex,
  input  logic [1:0]       Shift_op_Ex,
  input  logic [2:0]       ALUSrcB_Ex,
  input  logic             ALUShift_Sel_Ex,
  input  logic             Shift_amountSrc_Ex,
  input  logic             RegDst_Ex,
  input  logic             Jump_Ex,
  input  logic [2:0]       Condition_Ex,
  input  logic             RegWrite_Ex,
  input  logic             MemRead_Ex,
  input  logic             MemWrite_Ex,
  input  logic             stall_in,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_WriteReg,
  input  logic [WIDTH-1:0] WB_data,
  output logic [1:0]       PCSource,
  output logic [WIDTH-1:0] PC_branch,
  output logic [WIDTH-1:0] PC_jump,
  output logic             flush,
  output logic [WIDTH-1:0] ALU_result_Mem,
  output logic [WIDTH-1:0] Rt_out_Mem,
  output logic [4:0]       WriteReg_Mem,
  output logic             RegWrite_Mem,
  output logic             MemRead_Mem,
  output logic             MemWrite_Mem,
  output logic             valid_Mem
);

  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] sh_res;
  logic [WIDTH-1:0] result;
  logic [4:0]       sh_amt;
  logic [4:0]       write_reg;
  logic             taken;
  logic             qual;
  logic             rs_neg;
  logic             rs_zero;

`ifdef FORWARD_EN
  // Mem is the younger producer, so it overrides WB.
  always_comb begin
    rs_val = Rs_out_Ex;
    if (RegWrite_Mem && WriteReg_Mem == Rs_Ex && Rs_Ex != 5'd0)
      rs_val = ALU_result_Mem;
    else if (WB_RegWrite && WB_WriteReg == Rs_Ex && Rs_Ex != 5'd0)
      rs_val = WB_data;
  end

  always_comb begin
    rt_val = Rt_out_Ex;
    if (RegWrite_Mem && WriteReg_Mem == Rt_Ex && Rt_Ex != 5'd0)
      rt_val = ALU_result_Mem;
    else if (WB_RegWrite && WB_WriteReg == Rt_Ex && Rt_Ex != 5'd0)
      rt_val = WB_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{Rs_Ex, Rt_Ex, WB_RegWrite, WB_WriteReg, WB_data};
  assign rs_val = Rs_out_Ex;
  assign rt_val = Rt_out_Ex;
`endif

  always_comb begin
    op_b = '0;
    unique case (ALUSrcB_Ex)
      3'd0:    op_b = rt_val;
      3'd1:    op_b = offset_Ex;
      3'd2:    op_b = '0;
      3'd3:    op_b = PCP4_Ex;
      3'd4:    op_b = {offset_Ex[15:0], 16'h0000};
      default: op_b = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (ALU_op_Ex)
      4'd0:    alu_res = rs_val + op_b;
      4'd1:    alu_res = rs_val - op_b;
      4'd2:    alu_res = rs_val & op_b;
      4'd3:    alu_res = rs_val | op_b;
      4'd4:    alu_res = rs_val ^ op_b;
      4'd5:    alu_res = ~(rs_val | op_b);
      4'd6:    alu_res = {{(WIDTH-1){1'b0}},
                          $signed(rs_val) < $signed(op_b)};
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, rs_val < op_b};
      4'd8:    alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  assign sh_amt = Shift_amountSrc_Ex ? rs_val[4:0] : Shamt_Ex;

  // A zero rotate shifts left by WIDTH, which yields 0 and leaves rt intact.
  always_comb begin
    sh_res = '0;
    unique case (Shift_op_Ex)
      2'd0: sh_res = rt_val << sh_amt;
      2'd1: sh_res = rt_val >> sh_amt;
      2'd2: sh_res = $signed(rt_val) >>> sh_amt;
      2'd3: sh_res = (rt_val >> sh_amt) |
                     (rt_val << (6'd32 - {1'b0, sh_amt}));
    endcase
  end

  assign result = ALUShift_Sel_Ex ? sh_res : alu_res;

  assign rs_neg  = rs_val[WIDTH-1];
  assign rs_zero = (rs_val == '0);

  always_comb begin
    taken = 1'b0;
    unique case (Condition_Ex)
      3'd1:    taken = (rs_val == rt_val);
      3'd2:    taken = (rs_val != rt_val);
      3'd3:    taken = rs_neg | rs_zero;
      3'd4:    taken = !rs_neg && !rs_zero;
      3'd5:    taken = rs_neg;
      3'd6:    taken = !rs_neg;
      default: taken = 1'b0;
    endcase
  end

  assign PC_branch = PCP4_Ex + (offset_Ex << 2);
  assign PC_jump   = {PCP4_Ex[31:28], Target_Ex, 2'b00};

  // A stalled branch stays in ID/Ex and is resolved again on release.
  assign qual = valid_Ex && !stall_in && !reset;

  always_comb begin
    PCSource = 2'd0;
    if (qual && Jump_Ex)
      PCSource = 2'd2;
    else if (qual && taken)
      PCSource = 2'd1;
  end

  assign flush     = (PCSource != 2'd0);
  assign write_reg = RegDst_Ex ? Rd_Ex : Rt_Ex;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALU_result_Mem <= '0;
      Rt_out_Mem     <= '0;
      WriteReg_Mem   <= '0;
      RegWrite_Mem   <= 1'b0;
      MemRead_Mem    <= 1'b0;
      MemWrite_Mem   <= 1'b0;
      valid_Mem      <= 1'b0;
    end else if (!stall_in) begin
      if (valid_Ex) begin
        ALU_result_Mem <= result;
        Rt_out_Mem     <= rt_val;
        WriteReg_Mem   <= write_reg;
        RegWrite_Mem   <= RegWrite_Ex && (write_reg != 5'd0);
        MemRead_Mem    <= MemRead_Ex;
        MemWrite_Mem   <= MemWrite_Ex;
        valid_Mem      <= 1'b1;
      end else begin
        RegWrite_Mem <= 1'b0;
        MemRead_Mem  <= 1'b0;
        MemWrite_Mem <= 1'b0;
        valid_Mem    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage.
// Expected Ex/Mem contents are queued at drive time, checked after the edge.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_Ex;
  logic [31:0] PCP4_Ex, Rs_out_Ex, Rt_out_Ex, offset_Ex;
  logic [25:0] Target_Ex;
  logic [4:0]  Rs_Ex, Rt_Ex, Rd_Ex, Shamt_Ex;
  logic [3:0]  ALU_op_Ex;
  logic [1:0]  Shift_op_Ex;
  logic [2:0]  ALUSrcB_Ex;
  logic        ALUShift_Sel_Ex, Shift_amountSrc_Ex, RegDst_Ex, Jump_Ex;
  logic [2:0]  Condition_Ex;
  logic        RegWrite_Ex, MemRead_Ex, MemWrite_Ex, stall_in;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_data;
  logic [1:0]  PCSource;
  logic [31:0] PC_branch, PC_jump, ALU_result_Mem, Rt_out_Mem;
  logic        flush;
  logic [4:0]  WriteReg_Mem;
  logic        RegWrite_Mem, MemRead_Mem, MemWrite_Mem, valid_Mem;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid_Ex(valid_Ex),
    .PCP4_Ex(PCP4_Ex), .Rs_out_Ex(Rs_out_Ex), .Rt_out_Ex(Rt_out_Ex),
    .offset_Ex(offset_Ex), .Target_Ex(Target_Ex),
    .Rs_Ex(Rs_Ex), .Rt_Ex(Rt_Ex), .Rd_Ex(Rd_Ex), .Shamt_Ex(Shamt_Ex),
    .ALU_op_Ex(ALU_op_Ex), .Shift_op_Ex(Shift_op_Ex),
    .ALUSrcB_Ex(ALUSrcB_Ex), .ALUShift_Sel_Ex(ALUShift_Sel_Ex),
    .Shift_amountSrc_Ex(Shift_amountSrc_Ex), .RegDst_Ex(RegDst_Ex),
    .Jump_Ex(Jump_Ex), .Condition_Ex(Condition_Ex),
    .RegWrite_Ex(RegWrite_Ex), .MemRead_Ex(MemRead_Ex),
    .MemWrite_Ex(MemWrite_Ex), .stall_in(stall_in),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .WB_data(WB_data), .PCSource(PCSource), .PC_branch(PC_branch),
    .PC_jump(PC_jump), .flush(flush), .ALU_result_Mem(ALU_result_Mem),
    .Rt_out_Mem(Rt_out_Mem), .WriteReg_Mem(WriteReg_Mem),
    .RegWrite_Mem(RegWrite_Mem), .MemRead_Mem(MemRead_Mem),
    .MemWrite_Mem(MemWrite_Mem), .valid_Mem(valid_Mem)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        v;
  } mem_t;

  mem_t q[$];
  mem_t m;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] src,
                                      input logic [31:0] raw);
    logic [31:0] v;
    v = raw;
`ifdef FORWARD_EN
    if (src != 0 && WB_RegWrite && WB_WriteReg == src) v = WB_data;
    if (src != 0 && m.rw && m.wr == src) v = m.alu;
`endif
    return v;
  endfunction

  function automatic logic [31:0] model_res(input logic [31:0] a,
                                            input logic [31:0] rt);
    logic [31:0] b, r;
    logic [4:0]  sh;
    case (ALUSrcB_Ex)
      3'd0: b = rt;
      3'd1: b = offset_Ex;
      3'd3: b = PCP4_Ex;
      3'd4: b = offset_Ex << 16;
      default: b = 32'd0;
    endcase
    if (ALUShift_Sel_Ex) begin
      sh = Shift_amountSrc_Ex ? a[4:0] : Shamt_Ex;
      r = rt;
      for (int i = 0; i < 32; i++) begin
        if (i < int'(sh)) begin
          case (Shift_op_Ex)
            2'd0: r = {r[30:0], 1'b0};
            2'd1: r = {1'b0, r[31:1]};
            2'd2: r = {r[31], r[31:1]};
            default: r = {r[0], r[31:1]};
          endcase
        end
      end
      return r;
    end
    case (ALU_op_Ex)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: return (a < b) ? 32'd1 : 32'd0;
      4'd8: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic cond(input logic [31:0] a, input logic [31:0] b);
    case (Condition_Ex)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return $signed(a) <= 0;
      3'd4: return $signed(a) > 0;
      3'd5: return $signed(a) < 0;
      3'd6: return $signed(a) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear();
    valid_Ex = 0; PCP4_Ex = 0; Rs_out_Ex = 0; Rt_out_Ex = 0;
    offset_Ex = 0; Target_Ex = 0; Rs_Ex = 0; Rt_Ex = 0; Rd_Ex = 0;
    Shamt_Ex = 0; ALU_op_Ex = 0; Shift_op_Ex = 0; ALUSrcB_Ex = 0;
    ALUShift_Sel_Ex = 0; Shift_amountSrc_Ex = 0; RegDst_Ex = 0;
    Jump_Ex = 0; Condition_Ex = 0; RegWrite_Ex = 0; MemRead_Ex = 0;
    MemWrite_Ex = 0; stall_in = 0; WB_RegWrite = 0; WB_WriteReg = 0;
    WB_data = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":alu"}, ALU_result_Mem, 0);
    chk({tag, ":rt"}, Rt_out_Mem, 0);
    chk({tag, ":wr"}, WriteReg_Mem, 0);
    chk({tag, ":rw"}, RegWrite_Mem, 0);
    chk({tag, ":mr"}, MemRead_Mem, 0);
    chk({tag, ":mw"}, MemWrite_Mem, 0);
    chk({tag, ":v"}, valid_Mem, 0);
    chk({tag, ":pcs"}, PCSource, 0);
    chk({tag, ":flush"}, flush, 0);
  endtask

  // Checks redirect outputs now, queues the expected Ex/Mem state,
  // then clocks and compares against the popped entry.
  task automatic step(input string tag);
    mem_t nx, e;
    logic [31:0] a, rt;
    logic [1:0]  pcs;
    logic [4:0]  wr;
    #1;
    a  = fwd(Rs_Ex, Rs_out_Ex);
    rt = fwd(Rt_Ex, Rt_out_Ex);
    pcs = 2'd0;
    if (valid_Ex && !stall_in && !reset)
      pcs = Jump_Ex ? 2'd2 : (cond(a, rt) ? 2'd1 : 2'd0);
    chk({tag, ":pcs"}, PCSource, pcs);
    chk({tag, ":flush"}, flush, pcs != 0);
    chk({tag, ":pcb"}, PC_branch, PCP4_Ex + {offset_Ex[29:0], 2'b00});
    chk({tag, ":pcj"}, PC_jump, {PCP4_Ex[31:28], Target_Ex, 2'b00});
    wr = RegDst_Ex ? Rd_Ex : Rt_Ex;
    nx = m;
    if (reset) nx = '0;
    else if (!stall_in) begin
      nx.v  = valid_Ex;
      nx.rw = valid_Ex && RegWrite_Ex && wr != 0;
      nx.mr = valid_Ex && MemRead_Ex;
      nx.mw = valid_Ex && MemWrite_Ex;
      if (valid_Ex) begin
        nx.alu = model_res(a, rt);
        nx.rt  = rt;
        nx.wr  = wr;
      end
    end
    q.push_back(nx);
    @(posedge clk);
    m = nx;
    #1;
    if (q.size() == 0) begin
      chk({tag, ":sb_empty"}, 1, 0);
    end else begin
      e = q.pop_front();
      chk({tag, ":alu"}, ALU_result_Mem, e.alu);
      chk({tag, ":rt"}, Rt_out_Mem, e.rt);
      chk({tag, ":wr"}, WriteReg_Mem, e.wr);
      chk({tag, ":rw"}, RegWrite_Mem, e.rw);
      chk({tag, ":mr"}, MemRead_Mem, e.mr);
      chk({tag, ":mw"}, MemWrite_Mem, e.mw);
      chk({tag, ":v"}, valid_Mem, e.v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear();
    reset = 1;
    m = '0;
    #1;
    chk_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 0;

    // ADD overflow wraps
    clear();
    valid_Ex = 1; Rs_out_Ex = 32'h7FFFFFFF; Rt_out_Ex = 1;
    Rs_Ex = 1; Rt_Ex = 2; RegDst_Ex = 1; Rd_Ex = 5; RegWrite_Ex = 1;
    step("add");
    chk("add_c", ALU_result_Mem, 32'h80000000);
    chk("add_wr", WriteReg_Mem, 5);
    chk("add_v", valid_Mem, 1);

    clear();
    valid_Ex = 1; Rt_out_Ex = 32'h80000010; Rt_Ex = 7; Shamt_Ex = 4;
    Shift_op_Ex = 2; ALUShift_Sel_Ex = 1;
    step("sra");
    chk("sra_c", ALU_result_Mem, 32'hF8000001);

    clear();
    valid_Ex = 1; Rs_out_Ex = 3; Rt_out_Ex = 3; Rs_Ex = 8; Rt_Ex = 9;
    PCP4_Ex = 32'h100; offset_Ex = 32'hFFFFFFFE; Condition_Ex = 1;
    #1;
    chk("beq_pcs", PCSource, 1);
    chk("beq_pcb", PC_branch, 32'hF8);
    chk("beq_flush", flush, 1);
    step("beq");
    stall_in = 1;
    #1;
    chk("beq_st_pcs", PCSource, 0);
    chk("beq_st_flush", flush, 0);
    step("beq_stall");

    clear();
    valid_Ex = 1; Jump_Ex = 1; Condition_Ex = 1; Rs_out_Ex = 4;
    Rt_out_Ex = 4; PCP4_Ex = 32'h40000004; Target_Ex = 26'h10;
    #1;
    chk("jmp_pcs", PCSource, 2);
    chk("jmp_pcj", PC_jump, 32'h40000040);
    step("jmp");

    clear();
    valid_Ex = 1; Rs_out_Ex = 9; Rt_out_Ex = 1; RegDst_Ex = 1;
    Rd_Ex = 0; RegWrite_Ex = 1;
    step("r0");
    chk("r0_rw", RegWrite_Mem, 0);

    clear();
    RegWrite_Ex = 1; MemWrite_Ex = 1;
    step("bubble");
    chk("bubble_v", valid_Mem, 0);

`ifdef FORWARD_EN
    clear();
    valid_Ex = 1; Rs_Ex = 1; Rs_out_Ex = 10; Rt_Ex = 2; Rt_out_Ex = 20;
    RegDst_Ex = 1; Rd_Ex = 3; RegWrite_Ex = 1;
    step("fw_add");
    Rs_Ex = 3; Rs_out_Ex = 999; Rt_Ex = 1; Rt_out_Ex = 10;
    ALU_op_Ex = 1; Rd_Ex = 4;
    step("fw_sub");
    chk("fw_sub_c", ALU_result_Mem, 20);
    Rs_Ex = 1; Rs_out_Ex = 100; Rt_Ex = 2; Rt_out_Ex = 5;
    ALU_op_Ex = 0; Rd_Ex = 3;
    step("fw_add2");
    Rs_Ex = 3; Rs_out_Ex = 7; ALUSrcB_Ex = 2; Rd_Ex = 6;
    WB_RegWrite = 1; WB_WriteReg = 3; WB_data = 32'hDEAD;
    step("fw_pri");
    chk("fw_pri_c", ALU_result_Mem, 105);
    step("fw_wb");
    chk("fw_wb_c", ALU_result_Mem, 32'hDEAD);
`endif

    for (int i = 0; i < 60; i++) begin
      valid_Ex = ($urandom_range(3) != 0);
      stall_in = ($urandom_range(3) == 0);
      PCP4_Ex = $urandom; Rs_out_Ex = $urandom; Rt_out_Ex = $urandom;
      if ($urandom_range(3) == 0) Rt_out_Ex = Rs_out_Ex;
      offset_Ex = $urandom; Target_Ex = 26'($urandom);
      Rs_Ex = 5'($urandom); Rt_Ex = 5'($urandom);
      Rd_Ex = 5'($urandom); Shamt_Ex = 5'($urandom);
      ALU_op_Ex = 4'($urandom); Shift_op_Ex = 2'($urandom);
      ALUSrcB_Ex = 3'($urandom);
      ALUShift_Sel_Ex = 1'($urandom); Shift_amountSrc_Ex = 1'($urandom);
      RegDst_Ex = 1'($urandom); Jump_Ex = ($urandom_range(7) == 0);
      Condition_Ex = 3'($urandom); RegWrite_Ex = 1'($urandom);
      MemRead_Ex = 1'($urandom); MemWrite_Ex = 1'($urandom);
      WB_RegWrite = 1'($urandom); WB_WriteReg = 5'($urandom);
      WB_data = $urandom;
      step("rand");
    end

    // async reset between edges, with a live jump on the inputs
    clear();
    valid_Ex = 1; Jump_Ex = 1; RegWrite_Ex = 1;
    #2;
    reset = 1;
    #1;
    m = '0;
    chk_zero("rst_mid");
    stall_in = 1;
    @(posedge clk); #1;
    reset = 0;
    step("rst_stall");
    stall_in = 0; Jump_Ex = 0; Rs_out_Ex = 2; Rt_out_Ex = 3;
    Rt_Ex = 4;
    step("rst_rel");
    chk("rst_rel_v", valid_Mem, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
